// File: rtl/write_back.sv
// write_back: commits memory-stage results into A, B and carry, with bypass and a per-register pending-write scoreboard.
//   Clock, Reset           : pipeline clock, synchronous active-high reset
//   iData, iModA, iModB    : result bus and register write enables
//   iCarry_flag, iCarryWrite : carry value and its write enable
//   iIssueModA/B           : decode issued a future writer of A/B
//   oRegA, oRegB, oCarry   : architectural state
//   oFwdA, oFwdB           : same-cycle bypass values
//   oBusyA, oBusyB         : pending writes outstanding
//   oRetired               : committed-instruction counter (wraps)
//   oError                 : sticky scoreboard overflow/underflow
module write_back #(
    parameter int PEND_MAX = 3,
    parameter int PEND_W   = 2,
    parameter int RET_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [7:0]       iData,
    input  logic             iModA,
    input  logic             iModB,
    input  logic             iCarry_flag,
    input  logic             iCarryWrite,
    input  logic             iIssueModA,
    input  logic             iIssueModB,
    output logic [7:0]       oRegA,
    output logic [7:0]       oRegB,
    output logic             oCarry,
    output logic [7:0]       oFwdA,
    output logic [7:0]       oFwdB,
    output logic             oBusyA,
    output logic             oBusyB,
    output logic [RET_W-1:0] oRetired,
    output logic             oError
);
    localparam logic [PEND_W-1:0] MAX = PEND_W'(PEND_MAX);
    logic [PEND_W-1:0] cntA, cntB, cntANext, cntBNext;
    logic ovfA, unfA, ovfB, unfB;
    always_comb begin
        ovfA     = iIssueModA && !iModA && cntA == MAX;
        unfA     = iModA && !iIssueModA && cntA == '0;
        ovfB     = iIssueModB && !iModB && cntB == MAX;
        unfB     = iModB && !iIssueModB && cntB == '0;
        // saturate at both ends so a faulty pipeline cannot wrap the count
        cntANext = (ovfA || unfA) ? cntA :
                   (iIssueModA && !iModA) ? cntA + 1'b1 :
                   (iModA && !iIssueModA) ? cntA - 1'b1 : cntA;
        cntBNext = (ovfB || unfB) ? cntB :
                   (iIssueModB && !iModB) ? cntB + 1'b1 :
                   (iModB && !iIssueModB) ? cntB - 1'b1 : cntB;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oRegA    <= '0;
            oRegB    <= '0;
            oCarry   <= 1'b0;
            cntA     <= '0;
            cntB     <= '0;
            oRetired <= '0;
            oError   <= 1'b0;
        end else begin
            if (iModA) oRegA <= iData;
            if (iModB) oRegB <= iData;
            if (iCarryWrite) oCarry <= iCarry_flag;
            cntA <= cntANext;
            cntB <= cntBNext;
            if (iModA || iModB || iCarryWrite) oRetired <= oRetired + 1'b1;
            if (ovfA || unfA || ovfB || unfB) oError <= 1'b1;
        end
    end
    assign oFwdA  = iModA ? iData : oRegA;
    assign oFwdB  = iModB ? iData : oRegB;
    assign oBusyA = cntA != '0;
    assign oBusyB = cntB != '0;
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed stimulus with a behavioural reference model and per-cycle output comparison.
module tb_write_back;
    logic        Clock = 0;
    logic        Reset = 1;
    logic [7:0]  iData = 0;
    logic        iModA = 0, iModB = 0, iCarry_flag = 0, iCarryWrite = 0, iIssueModA = 0, iIssueModB = 0;
    logic [7:0]  oRegA, oRegB, oFwdA, oFwdB;
    logic        oCarry, oBusyA, oBusyB, oError;
    logic [15:0] oRetired;
    int vectors = 0, miscompares = 0;
    bit started = 0;
    int mRegA, mRegB, mCarry, mCntA, mCntB, mRet, mErr;

    write_back dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iModA(iModA), .iModB(iModB),
        .iCarry_flag(iCarry_flag), .iCarryWrite(iCarryWrite), .iIssueModA(iIssueModA),
        .iIssueModB(iIssueModB), .oRegA(oRegA), .oRegB(oRegB), .oCarry(oCarry),
        .oFwdA(oFwdA), .oFwdB(oFwdB), .oBusyA(oBusyA), .oBusyB(oBusyB),
        .oRetired(oRetired), .oError(oError)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: architectural state as plain integers, counts clamped to [0, 3]
    always @(posedge Clock) begin
        if (Reset) begin
            started = 1;
            mRegA = 0; mRegB = 0; mCarry = 0; mCntA = 0; mCntB = 0; mRet = 0; mErr = 0;
        end else begin
            if (iModA) mRegA = iData;
            if (iModB) mRegB = iData;
            if (iCarryWrite) mCarry = iCarry_flag;
            if (iModA || iModB || iCarryWrite) mRet = (mRet + 1) % 65536;
            mCntA = mCntA + int'(iIssueModA) - int'(iModA);
            mCntB = mCntB + int'(iIssueModB) - int'(iModB);
            if (mCntA > 3 || mCntA < 0 || mCntB > 3 || mCntB < 0) mErr = 1;
            mCntA = mCntA > 3 ? 3 : mCntA < 0 ? 0 : mCntA;
            mCntB = mCntB > 3 ? 3 : mCntB < 0 ? 0 : mCntB;
        end
    end

    always @(negedge Clock) if (started) begin
        chk("regA", oRegA, mRegA);
        chk("regB", oRegB, mRegB);
        chk("carry", oCarry, mCarry);
        chk("fwdA", oFwdA, iModA ? iData : mRegA);
        chk("fwdB", oFwdB, iModB ? iData : mRegB);
        chk("busyA", oBusyA, mCntA != 0);
        chk("busyB", oBusyB, mCntB != 0);
        chk("retired", oRetired, mRet);
        chk("error", oError, mErr);
    end

    task automatic cyc(input logic [7:0] d, input logic ma, mb, cf, cw, ia, ib);
        iData = d; iModA = ma; iModB = mb; iCarry_flag = cf; iCarryWrite = cw; iIssueModA = ia; iIssueModB = ib;
        @(posedge Clock); #1;
    endtask

    task automatic idle();
        cyc(8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        idle(); idle();
        Reset = 0;
        idle();
        chk("rst regA", oRegA, 8'h00);
        chk("rst busyA", oBusyA, 0);
        chk("rst retired", oRetired, 0);
        chk("rst error", oError, 0);
        // reset over two pending A writes, with a commit presented in the reset cycle
        cyc(8'h00, 0, 0, 0, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 0, 1, 0);
        chk("pend2 busyA", oBusyA, 1);
        Reset = 1;
        cyc(8'h77, 1, 0, 0, 0, 0, 0);
        Reset = 0;
        chk("rst2 busyA", oBusyA, 0);
        chk("rst2 regA", oRegA, 8'h00);
        chk("rst2 retired", oRetired, 0);
        // single A commit with same-cycle bypass (underflows: A not issued)
        iData = 8'h5A; iModA = 1; #1;
        chk("bypass fwdA", oFwdA, 8'h5A);
        chk("bypass fwdB", oFwdB, 8'h00);
        @(posedge Clock); #1;
        idle();
        chk("commit regA", oRegA, 8'h5A);
        chk("commit regB", oRegB, 8'h00);
        chk("commit retired", oRetired, 1);
        chk("underflow error", oError, 1);
        Reset = 1; idle(); Reset = 0;
        // dual commit plus carry, then carry must hold
        cyc(8'h00, 0, 0, 0, 0, 1, 1);
        cyc(8'hC3, 1, 1, 1, 1, 0, 0);
        chk("dual regA", oRegA, 8'hC3);
        chk("dual regB", oRegB, 8'hC3);
        chk("dual carry", oCarry, 1);
        cyc(8'h00, 0, 0, 0, 0, 0, 0);
        chk("carry hold", oCarry, 1);
        chk("dual retired", oRetired, 1);
        chk("dual error", oError, 0);
        // issue A at 0,1,2; retire at 2,4,5
        cyc(8'h00, 0, 0, 0, 0, 1, 0); chk("busy e0", oBusyA, 1);
        cyc(8'h00, 0, 0, 0, 0, 1, 0); chk("busy e1", oBusyA, 1);
        cyc(8'h11, 1, 0, 0, 0, 1, 0); chk("busy e2", oBusyA, 1);
        cyc(8'h00, 0, 0, 0, 0, 0, 0); chk("busy e3", oBusyA, 1);
        cyc(8'h22, 1, 0, 0, 0, 0, 0); chk("busy e4", oBusyA, 1);
        cyc(8'h33, 1, 0, 0, 0, 0, 0); chk("busy e5", oBusyA, 0);
        chk("busy regA", oRegA, 8'h33);
        chk("busy error", oError, 0);
        // overflow: four issues without retire
        repeat (3) cyc(8'h00, 0, 0, 0, 0, 1, 0);
        chk("pre-ovf error", oError, 0);
        cyc(8'h00, 0, 0, 0, 0, 1, 0);
        chk("ovf error", oError, 1);
        chk("ovf busyA", oBusyA, 1);
        idle();
        chk("ovf sticky", oError, 1);
        // saturated count of 3 drains in exactly three retires
        repeat (2) cyc(8'h44, 1, 0, 0, 0, 0, 0);
        chk("drain busyA", oBusyA, 1);
        cyc(8'h44, 1, 0, 0, 0, 0, 0);
        chk("drained busyA", oBusyA, 0);
        Reset = 1; idle(); Reset = 0;
        chk("rst3 error", oError, 0);
        cyc(8'h99, 0, 1, 0, 0, 0, 0);
        chk("unfB error", oError, 1);
        chk("unfB regB", oRegB, 8'h99);
        chk("unfB busyB", oBusyB, 0);
        // retired counter wrap
        Reset = 1; idle(); Reset = 0;
        repeat (65535) cyc(8'h00, 0, 0, 1, 1, 0, 0);
        chk("ret max", oRetired, 16'hFFFF);
        cyc(8'h00, 0, 0, 0, 1, 0, 0);
        chk("ret wrap", oRetired, 16'h0000);
        chk("ret carry", oCarry, 0);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
